hw_ctrl_seq: RTL and testbench
==============================

# hw_ctrl_seq

Parametrised, self-sequencing hardwired controller for the 8-bit teaching CPU. It generates its own beat timing (W1/W2/W3, ST0 phase) from a free-running clock and handles console start/stop handshaking. It supports a configurable register-file size and an extended instruction set. It sits between the console switches and IR on one side and the datapath (register file, ALU, PC, AR, memory, buses) on the other.

## Interface
- REGS, 4, number of GPRs; power of 2, 2..16. Derived local RW = $clog2(REGS).
- EXT_ISA, 1, enables OR/CMP/MOV/OUT; when 0 those opcodes decode as NOP.
- clk  in  1  machine clock; one beat per rising edge while running.
- CLR  in  1  reset, asynchronous, active-low.
- start  in  1  console start pulse, sampled on clk.
- sw  in  3  console mode {SWC,SWB,SWA}: 000 run, 100 wr_reg, 011 rd_reg, 001 wr_mem, 010 rd_mem; others are illegal and decode as run.
- ir  in  4  opcode IR[7:4].
- c, z  in  1  carry and zero flags.
- w  out  3  one-hot beat {W3,W2,W1}.
- st0  out  1  phase flag.
- stop  out  1  waiting for start.
- sel  out  2*RW  {dst, src} register select.
- s  out  4  ALU function.
- selctl, drw, lpc, pcinc, pcadd, lar, arinc, lir, ldz, ldc, cin, m, memw, abus, sbus, mbus, outen  out  1 each  datapath strobes.

## Operation
- FSM states: IDLE (stop=1, w=000) and BEAT. In IDLE, a start pulse latches sw into the mode register. If the mode differs from the held mode, st0 and idx clear. The FSM then enters BEAT at W1.
- Beat sequence: W1→W2→(W3 only if long)→W1. Console beats are short (W1 only).
- wr_reg: each beat asserts selctl, sbus, drw, sel={idx,idx}. Afterwards idx increments and the FSM returns to IDLE. Idx wraps at REGS.
- rd_reg: each beat asserts selctl, sel={idx+1,idx}. Idx then steps by 2 and the FSM returns to IDLE.
- wr_mem / rd_mem, st0=0 beat: selctl, sbus, lar; then st0 sets.
- wr_mem, st0=1 beat: selctl, sbus, memw, arinc.
- rd_mem, st0=1 beat: selctl, mbus, arinc.
- All wr_mem / rd_mem beats return to IDLE afterwards.
- run, st0=0: W1 asserts sbus, lpc (PC loaded from switches); then st0 sets and the FSM returns to IDLE.
- run, st0=1: free-runs with no start needed. Every W1 asserts lir and pcinc. Execute signals by opcode (W2 unless noted):
  - 0000 NOP: no strobes.
  - 0001 ADD: s=1001, cin, abus, drw, ldz, ldc.
  - 0010 SUB: s=0110, abus, drw, ldz, ldc.
  - 0011 AND: s=1011, m, abus, drw, ldz.
  - 0100 INC: s=0000, abus, drw, ldz, ldc.
  - 0101 LD: s=1010, m, abus, lar, long. W3: mbus, drw.
  - 0110 ST: s=1111, m, abus, lar, long. W3: s=1010, m, abus, memw.
  - 0111 JC: pcadd if c.
  - 1000 JZ: pcadd if z.
  - 1001 JMP: s=1111, m, abus, lpc.
  - 1010 OUT: s=1010, m, abus, outen.
  - 1011 OR: s=1110, m, abus, drw, ldz.
  - 1100 CMP: s=0110, abus, ldz, ldc (no drw).
  - 1101 MOV: s=1010, m, abus, drw.
  - 1110 STP: stop=1 during W2; at end of W2 enter IDLE with st0 kept at 1, so the next start resumes fetch.
  - 1111: NOP.
- In run mode, sel is driven by the datapath (selctl=0), and this block drives sel=0.
- In all console modes, selctl=1.

## Timing
- All state updates on rising clk. Outputs are combinational from registered state (state, w, st0, idx, mode) plus ir, c, z.
- ir must be stable from the W1→W2 edge onward.
- Reset values:
  - w=000, st0=0, stop=1, idx=0, mode=run, s=0000, sel=0.
  - All strobes are 0.
- Start-to-W1 latency: 1 clk.
- start is ignored while stop=0, including the STP W2 cycle.
- CLR low mid-instruction: immediate return to IDLE with reset values. Partially issued strobes drop asynchronously.
- A start held high for multiple cycles triggers only once per IDLE entry; the FSM must see start low before re-arming.

## Structure
- Package hw_ctrl_pkg holds:
  - opcode localparams;
  - mode encodings;
  - ALU s codes;
  - the FSM state enum.
- Sub-module hw_beat_gen holds the IDLE/BEAT FSM, beat counter, st0, idx and the start edge detect.
- The top level holds the combinational decode.

## Test plan
- Reset, then release CLR: stop=1, w=000, all strobes 0. One start in wr_reg → one W1 beat with drw=1, sel=0000, then stop=1.
- wr_reg with REGS=4, five starts: sel sequence 0000, 0101, 1010, 1111, 0000 (idx wrap).
- wr_mem, three starts: beat 1 lar=1, st0 0→1. Beats 2 and 3 assert memw and arinc.
- run: start with st0=0 asserts lpc. Next start free-runs ADD then LD: ADD gives w 001→010 with cin=1, s=1001. LD gives w 001→010→100 with mbus=1, drw=1 in W3.
- STP in W2: stop=1, FSM goes to IDLE with st0=1. A start asserted in that W2 cycle is ignored. A later start resumes with W1 lir=1.
- EXT_ISA=0 with ir=1011: W2 with no drw/ldz. CLR pulled low during LD W3 → outputs return to reset values on the same cycle.

Source files
------------

// File: rtl/hw_ctrl_pkg.sv
// hw_ctrl_pkg: opcodes, console modes, ALU function codes and sequencer states
// shared by the hardwired controller and its beat generator.
package hw_ctrl_pkg;
  localparam logic [3:0] OP_NOP = 4'h0, OP_ADD = 4'h1, OP_SUB = 4'h2, OP_AND = 4'h3;
  localparam logic [3:0] OP_INC = 4'h4, OP_LD = 4'h5, OP_ST = 4'h6, OP_JC = 4'h7;
  localparam logic [3:0] OP_JZ = 4'h8, OP_JMP = 4'h9, OP_OUT = 4'hA, OP_OR = 4'hB;
  localparam logic [3:0] OP_CMP = 4'hC, OP_MOV = 4'hD, OP_STP = 4'hE;
  localparam logic [3:0] ALU_INC = 4'b0000, ALU_SUB = 4'b0110, ALU_ADD = 4'b1001, ALU_PASS = 4'b1010;
  localparam logic [3:0] ALU_AND = 4'b1011, ALU_OR = 4'b1110, ALU_A = 4'b1111;
  localparam logic [2:0] W1 = 3'b001, W2 = 3'b010, W3 = 3'b100;
  typedef enum logic [2:0] {
    MODE_RUN    = 3'b000,
    MODE_WR_MEM = 3'b001,
    MODE_RD_MEM = 3'b010,
    MODE_RD_REG = 3'b011,
    MODE_WR_REG = 3'b100
  } mode_t;
  typedef enum logic {S_IDLE, S_BEAT} state_t;
  // Unlisted switch patterns fall back to run mode.
  function automatic mode_t decode_mode(input logic [2:0] sw);
    return (sw inside {3'b001, 3'b010, 3'b011, 3'b100}) ? mode_t'(sw) : MODE_RUN;
  endfunction
endpackage

// File: rtl/hw_beat_gen.sv
// hw_beat_gen: IDLE/BEAT sequencer holding beat, st0 phase, register index,
// console mode and the start edge detect.
module hw_beat_gen import hw_ctrl_pkg::*; #(
  parameter int RW = 2
) (
  input  logic          clk,
  input  logic          CLR,
  input  logic          start,
  input  logic [2:0]    sw,
  input  logic [3:0]    ir,
  output state_t        state,
  output logic [2:0]    w,
  output logic          st0,
  output logic [RW-1:0] idx,
  output mode_t         mode
);
  state_t state_q, state_d;
  logic [2:0] w_q, w_d;
  logic st0_q, st0_d, start_q;
  logic [RW-1:0] idx_q, idx_d;
  mode_t mode_q, mode_d;
  always_ff @(posedge clk or negedge CLR)
    if (!CLR) begin
      state_q <= S_IDLE;
      w_q <= '0;
      st0_q <= 1'b0;
      idx_q <= '0;
      mode_q <= MODE_RUN;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      st0_q <= st0_d;
      idx_q <= idx_d;
      mode_q <= mode_d;
      start_q <= start;
    end
  always_comb begin
    state_d = state_q;
    w_d = w_q;
    st0_d = st0_q;
    idx_d = idx_q;
    mode_d = mode_q;
    if (state_q == S_IDLE) begin
      if (start && !start_q) begin
        mode_d = decode_mode(sw);
        state_d = S_BEAT;
        w_d = W1;
        if (mode_d != mode_q) begin
          st0_d = 1'b0;
          idx_d = '0;
        end
      end
    end else if (mode_q != MODE_RUN || !st0_q) begin
      // single-beat console / PC-load step, then wait for the next start
      state_d = S_IDLE;
      w_d = '0;
      st0_d = (mode_q inside {MODE_WR_REG, MODE_RD_REG}) ? st0_q : 1'b1;
      idx_d = idx_q + ((mode_q == MODE_WR_REG) ? RW'(1) : (mode_q == MODE_RD_REG) ? RW'(2) : RW'(0));
    end else if (w_q == W2 && ir == OP_STP) begin
      state_d = S_IDLE;
      w_d = '0;
    end else begin
      w_d = (w_q == W1) ? W2 : (w_q == W2 && ir inside {OP_LD, OP_ST}) ? W3 : W1;
    end
  end
  assign state = state_q;
  assign w = w_q;
  assign st0 = st0_q;
  assign idx = idx_q;
  assign mode = mode_q;
endmodule

// File: rtl/hw_ctrl_seq.sv
// hw_ctrl_seq: self-sequencing hardwired controller for the 8-bit teaching CPU;
// decodes beat, phase, mode and opcode into datapath strobes.
module hw_ctrl_seq import hw_ctrl_pkg::*; #(
  parameter int REGS    = 4,
  parameter bit EXT_ISA = 1'b1
) (
  input  logic                       clk,
  input  logic                       CLR,
  input  logic                       start,
  input  logic [2:0]                 sw,
  input  logic [3:0]                 ir,
  input  logic                       c,
  input  logic                       z,
  output logic [2:0]                 w,
  output logic                       st0,
  output logic                       stop,
  output logic [2*$clog2(REGS)-1:0]  sel,
  output logic [3:0]                 s,
  output logic                       selctl,
  output logic                       drw,
  output logic                       lpc,
  output logic                       pcinc,
  output logic                       pcadd,
  output logic                       lar,
  output logic                       arinc,
  output logic                       lir,
  output logic                       ldz,
  output logic                       ldc,
  output logic                       cin,
  output logic                       m,
  output logic                       memw,
  output logic                       abus,
  output logic                       sbus,
  output logic                       mbus,
  output logic                       outen
);
  localparam int RW = $clog2(REGS);
  state_t state;
  mode_t mode;
  logic [RW-1:0] idx;
  logic [3:0] op;
  hw_beat_gen #(.RW(RW)) u_beat (
    .clk(clk), .CLR(CLR), .start(start), .sw(sw), .ir(ir),
    .state(state), .w(w), .st0(st0), .idx(idx), .mode(mode)
  );
  assign op = (!EXT_ISA && ir inside {OP_OUT, OP_OR, OP_CMP, OP_MOV}) ? OP_NOP : ir;
  always_comb begin
    stop = (state == S_IDLE);
    sel = '0;
    s = '0;
    {selctl, drw, lpc, pcinc, pcadd, lar, arinc, lir, ldz, ldc, cin, m, memw, abus, sbus, mbus, outen} = '0;
    if (state == S_BEAT) begin
      if (mode != MODE_RUN) begin
        selctl = 1'b1;
        sel = (mode == MODE_WR_REG) ? {idx, idx} : (mode == MODE_RD_REG) ? {idx + RW'(1), idx} : '0;
        drw = (mode == MODE_WR_REG);
        sbus = mode == MODE_WR_REG || mode == MODE_WR_MEM || (mode == MODE_RD_MEM && !st0);
        lar = (mode inside {MODE_WR_MEM, MODE_RD_MEM}) && !st0;
        arinc = (mode inside {MODE_WR_MEM, MODE_RD_MEM}) && st0;
        memw = (mode == MODE_WR_MEM) && st0;
        mbus = (mode == MODE_RD_MEM) && st0;
      end else if (!st0) begin
        sbus = 1'b1;
        lpc = 1'b1;
      end else if (w == W1) begin
        lir = 1'b1;
        pcinc = 1'b1;
      end else begin
        case (op)
          OP_ADD: begin s = ALU_ADD; cin = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
          OP_SUB: begin s = ALU_SUB; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
          OP_AND: begin s = ALU_AND; m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; end
          OP_INC: begin s = ALU_INC; abus = 1'b1; drw = 1'b1; ldz = 1'b1; ldc = 1'b1; end
          OP_LD:  if (w == W2) begin s = ALU_PASS; m = 1'b1; abus = 1'b1; lar = 1'b1; end
                  else begin mbus = 1'b1; drw = 1'b1; end
          OP_ST:  if (w == W2) begin s = ALU_A; m = 1'b1; abus = 1'b1; lar = 1'b1; end
                  else begin s = ALU_PASS; m = 1'b1; abus = 1'b1; memw = 1'b1; end
          OP_JC:  pcadd = c;
          OP_JZ:  pcadd = z;
          OP_JMP: begin s = ALU_A; m = 1'b1; abus = 1'b1; lpc = 1'b1; end
          OP_OUT: begin s = ALU_PASS; m = 1'b1; abus = 1'b1; outen = 1'b1; end
          OP_OR:  begin s = ALU_OR; m = 1'b1; abus = 1'b1; drw = 1'b1; ldz = 1'b1; end
          OP_CMP: begin s = ALU_SUB; abus = 1'b1; ldz = 1'b1; ldc = 1'b1; end
          OP_MOV: begin s = ALU_PASS; m = 1'b1; abus = 1'b1; drw = 1'b1; end
          OP_STP: stop = 1'b1;
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_hw_ctrl_seq.sv
// tb_hw_ctrl_seq: scoreboard bench; two controllers (full and base ISA) share
// stimulus and are checked beat by beat against a behavioural model.
module tb_hw_ctrl_seq;
  localparam int REGS = 4;
  typedef struct packed {
    logic [2:0] w;
    logic st0, stop;
    logic [3:0] sel, s;
    logic selctl, drw, lpc, pcinc, pcadd, lar, arinc, lir, ldz, ldc, cin, m, memw, abus, sbus, mbus, outen;
  } obs_t;
  typedef struct packed {obs_t a; obs_t b;} pair_t;
  logic clk = 1'b0, CLR = 1'b0, start = 1'b0, c = 1'b0, z = 1'b0;
  logic [2:0] sw = 3'b000;
  logic [3:0] ir = 4'h0;
  logic [2:0] a_w, b_w;
  logic [3:0] a_sel, b_sel, a_s, b_s;
  logic a_st0, a_stop, a_selctl, a_drw, a_lpc, a_pcinc, a_pcadd, a_lar, a_arinc, a_lir, a_ldz, a_ldc, a_cin, a_m, a_memw, a_abus, a_sbus, a_mbus, a_outen;
  logic b_st0, b_stop, b_selctl, b_drw, b_lpc, b_pcinc, b_pcadd, b_lar, b_arinc, b_lir, b_ldz, b_ldc, b_cin, b_m, b_memw, b_abus, b_sbus, b_mbus, b_outen;
  obs_t oa, ob, xa, xb;
  pair_t p;
  pair_t exp_q[$];
  logic [3:0] prog[$];
  int n_cmp = 0, n_bad = 0;
  int m_mode = 0, m_st0 = 0, m_idx = 0;

  always #5 clk = ~clk;

  hw_ctrl_seq #(.REGS(REGS), .EXT_ISA(1'b1)) dut_a (
    .clk(clk), .CLR(CLR), .start(start), .sw(sw), .ir(ir), .c(c), .z(z),
    .w(a_w), .st0(a_st0), .stop(a_stop), .sel(a_sel), .s(a_s), .selctl(a_selctl), .drw(a_drw),
    .lpc(a_lpc), .pcinc(a_pcinc), .pcadd(a_pcadd), .lar(a_lar), .arinc(a_arinc), .lir(a_lir),
    .ldz(a_ldz), .ldc(a_ldc), .cin(a_cin), .m(a_m), .memw(a_memw), .abus(a_abus), .sbus(a_sbus),
    .mbus(a_mbus), .outen(a_outen)
  );
  hw_ctrl_seq #(.REGS(REGS), .EXT_ISA(1'b0)) dut_b (
    .clk(clk), .CLR(CLR), .start(start), .sw(sw), .ir(ir), .c(c), .z(z),
    .w(b_w), .st0(b_st0), .stop(b_stop), .sel(b_sel), .s(b_s), .selctl(b_selctl), .drw(b_drw),
    .lpc(b_lpc), .pcinc(b_pcinc), .pcadd(b_pcadd), .lar(b_lar), .arinc(b_arinc), .lir(b_lir),
    .ldz(b_ldz), .ldc(b_ldc), .cin(b_cin), .m(b_m), .memw(b_memw), .abus(b_abus), .sbus(b_sbus),
    .mbus(b_mbus), .outen(b_outen)
  );
  assign oa = {a_w, a_st0, a_stop, a_sel, a_s, a_selctl, a_drw, a_lpc, a_pcinc, a_pcadd, a_lar, a_arinc,
               a_lir, a_ldz, a_ldc, a_cin, a_m, a_memw, a_abus, a_sbus, a_mbus, a_outen};
  assign ob = {b_w, b_st0, b_stop, b_sel, b_s, b_selctl, b_drw, b_lpc, b_pcinc, b_pcadd, b_lar, b_arinc,
               b_lir, b_ldz, b_ldc, b_cin, b_m, b_memw, b_abus, b_sbus, b_mbus, b_outen};

  task automatic chk(input string nm, input obs_t act, input obs_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  function automatic obs_t idle_obs();
    obs_t o = '0;
    o.stop = 1'b1;
    return o;
  endfunction

  function automatic obs_t fetch_obs();
    obs_t o = '0;
    o.w = 3'b001; o.st0 = 1'b1; o.lir = 1'b1; o.pcinc = 1'b1;
    return o;
  endfunction

  // Execute-beat strobes straight from the instruction table.
  function automatic obs_t exec_obs(input logic [3:0] op, input bit ext, input bit w3, input logic cc, input logic zz);
    obs_t o = '0;
    int e;
    e = (!ext && op >= 4'hA && op <= 4'hD) ? 0 : int'(op);
    o.w = w3 ? 3'b100 : 3'b010;
    o.st0 = 1'b1;
    case (e)
      1:  begin o.s = 4'b1001; o.cin = 1; o.abus = 1; o.drw = 1; o.ldz = 1; o.ldc = 1; end
      2:  begin o.s = 4'b0110; o.abus = 1; o.drw = 1; o.ldz = 1; o.ldc = 1; end
      3:  begin o.s = 4'b1011; o.m = 1; o.abus = 1; o.drw = 1; o.ldz = 1; end
      4:  begin o.s = 4'b0000; o.abus = 1; o.drw = 1; o.ldz = 1; o.ldc = 1; end
      5:  if (!w3) begin o.s = 4'b1010; o.m = 1; o.abus = 1; o.lar = 1; end
          else begin o.mbus = 1; o.drw = 1; end
      6:  if (!w3) begin o.s = 4'b1111; o.m = 1; o.abus = 1; o.lar = 1; end
          else begin o.s = 4'b1010; o.m = 1; o.abus = 1; o.memw = 1; end
      7:  o.pcadd = cc;
      8:  o.pcadd = zz;
      9:  begin o.s = 4'b1111; o.m = 1; o.abus = 1; o.lpc = 1; end
      10: begin o.s = 4'b1010; o.m = 1; o.abus = 1; o.outen = 1; end
      11: begin o.s = 4'b1110; o.m = 1; o.abus = 1; o.drw = 1; o.ldz = 1; end
      12: begin o.s = 4'b0110; o.abus = 1; o.ldz = 1; o.ldc = 1; end
      13: begin o.s = 4'b1010; o.m = 1; o.abus = 1; o.drw = 1; end
      14: o.stop = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic obs_t console_beat();
    obs_t o = '0;
    o.w = 3'b001;
    o.st0 = m_st0[0];
    case (m_mode)
      4: begin o.selctl = 1; o.sbus = 1; o.drw = 1; o.sel = {2'(m_idx), 2'(m_idx)}; m_idx = (m_idx + 1) % REGS; end
      3: begin o.selctl = 1; o.sel = {2'((m_idx + 1) % REGS), 2'(m_idx)}; m_idx = (m_idx + 2) % REGS; end
      1: begin o.selctl = 1; o.sbus = 1; if (m_st0 == 0) o.lar = 1; else begin o.memw = 1; o.arinc = 1; end m_st0 = 1; end
      2: begin o.selctl = 1; if (m_st0 == 0) begin o.sbus = 1; o.lar = 1; end else begin o.mbus = 1; o.arinc = 1; end m_st0 = 1; end
      default: begin o.sbus = 1; o.lpc = 1; m_st0 = 1; end
    endcase
    return o;
  endfunction

  task automatic push_instr(input logic [3:0] op, input logic cc, input logic zz);
    exp_q.push_back('{fetch_obs(), fetch_obs()});
    exp_q.push_back('{exec_obs(op, 1, 0, cc, zz), exec_obs(op, 0, 0, cc, zz)});
    if (op == 4'h5 || op == 4'h6) exp_q.push_back('{exec_obs(op, 1, 1, cc, zz), exec_obs(op, 0, 1, cc, zz)});
  endtask

  // One console start; in run mode with st0 set this free-runs prog (ending in STP).
  task automatic go(input logic [2:0] sv, input int hold);
    int nm, r, len;
    obs_t o;
    nm = (sv inside {3'b001, 3'b010, 3'b011, 3'b100}) ? int'(sv) : 0;
    if (nm != m_mode) begin m_st0 = 0; m_idx = 0; end
    m_mode = nm;
    sw = sv;
    if (m_mode == 0 && m_st0 == 1) begin
      if (prog.size() == 0) begin
        repeat ($urandom_range(1, 4)) begin
          r = $urandom_range(0, 14);
          prog.push_back(r == 14 ? 4'hF : 4'(r));
        end
        prog.push_back(4'hE);
      end
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      foreach (prog[k]) begin
        ir = prog[k];
        c = 1'($urandom);
        z = 1'($urandom);
        push_instr(prog[k], c, z);
        if (prog[k] == 4'hE) begin
          @(posedge clk); #1;
          start = 1'b1;
          @(posedge clk); #1;
          @(posedge clk); #1;
          start = 1'b0;
        end else begin
          len = (prog[k] == 4'h5 || prog[k] == 4'h6) ? 3 : 2;
          repeat (len) begin @(posedge clk); #1; end
        end
      end
      prog.delete();
    end else begin
      o = console_beat();
      exp_q.push_back('{o, o});
      start = 1'b1;
      repeat (hold) begin @(posedge clk); #1; end
      start = 1'b0;
    end
    repeat (2) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (oa.w != 3'b000 || ob.w != 3'b000) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat: got %h / %h, required no beat", oa, ob);
      end else begin
        p = exp_q.pop_front();
        chk("beat_a", oa, p.a);
        chk("beat_b", ob, p.b);
      end
    end else begin
      xa = oa; xa.st0 = 1'b0;
      xb = ob; xb.st0 = 1'b0;
      chk("idle_a", xa, idle_obs());
      chk("idle_b", xb, idle_obs());
    end
  end

  initial begin
    #12;
    chk("reset_a", oa, idle_obs());
    chk("reset_b", ob, idle_obs());
    @(posedge clk); #1;
    CLR = 1'b1;
    @(posedge clk); #1;
    repeat (5) go(3'b100, 1);
    repeat (3) go(3'b001, 1);
    go(3'b000, 1);
    prog = '{4'h1, 4'h5, 4'hE};
    go(3'b000, 1);
    prog = '{4'hB, 4'hC, 4'hD, 4'hA, 4'h6, 4'h7, 4'h8, 4'h9, 4'h4, 4'h2, 4'h3, 4'h0, 4'hF, 4'hE};
    go(3'b000, 1);
    repeat (40) go(3'($urandom_range(0, 7)), $urandom_range(1, 3));
    go(3'b000, 1);
    sw = 3'b000;
    ir = 4'h5;
    c = 1'b0;
    z = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_q.push_back('{fetch_obs(), fetch_obs()});
    exp_q.push_back('{exec_obs(4'h5, 1, 0, 0, 0), exec_obs(4'h5, 0, 0, 0, 0)});
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ld_w3_a", oa, exec_obs(4'h5, 1, 1, 0, 0));
    chk("ld_w3_b", ob, exec_obs(4'h5, 0, 1, 0, 0));
    CLR = 1'b0;
    #1;
    chk("clr_a", oa, idle_obs());
    chk("clr_b", ob, idle_obs());
    m_mode = 0;
    m_st0 = 0;
    m_idx = 0;
    @(posedge clk); #1;
    CLR = 1'b1;
    @(posedge clk); #1;
    repeat (3) go(3'b011, 1);
    repeat (2) go(3'b010, 2);
    go(3'b000, 1);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d beats still expected, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
